// File: rtl/ahb_resp_mem.sv
// ahb_resp_mem
//   AHB-Lite single-slave memory responder. Decodes one address window,
//   stores data in an internal 32-bit word array with byte-lane writes and
//   returns read data after a fixed number of wait states. Misaligned,
//   illegal-size or out-of-window transfers get the two-cycle ERROR response.
//
// Parameters
//   MEM_WORDS   number of 32-bit words (power of two, 4..65536)
//   BASE_ADDR   window base, aligned to 4*MEM_WORDS
//   WAIT_STATES wait cycles inserted per OKAY transfer (0..15)
//
// Ports
//   clk        bus clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   ahb_addr   address-phase byte address
//   ahb_trans  00 IDLE, 01 BUSY, 10 NSEQ, 11 SEQ
//   ahb_write  1 = write, 0 = read
//   ahb_wdata  data-phase write data, little-endian lanes
//   ahb_size   00 byte, 01 half-word, 10 word, 11 illegal
//   ahb_rdata  data-phase read data
//   ahb_ready  data phase completes this cycle; qualifies the address phase
//   ahb_resp   0 OKAY, 1 ERROR
module ahb_resp_mem #(
   parameter int unsigned MEM_WORDS   = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] ahb_addr,
   input  logic [1:0]  ahb_trans,
   input  logic        ahb_write,
   input  logic [31:0] ahb_wdata,
   input  logic [1:0]  ahb_size,
   output logic [31:0] ahb_rdata,
   output logic        ahb_ready,
   output logic        ahb_resp
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int WIN_W = IDX_W + 2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // Byte lanes touched by a transfer of the given size at the given offset.
   function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                              input logic [1:0] off);
      logic [3:0] strb;
      case (size)
         2'b00:   strb = 4'b0001 << off;
         2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Size/alignment legality; size 11 is never legal.
   function automatic logic align_err(input logic [1:0] size,
                                      input logic [1:0] off);
      logic err;
      case (size)
         2'b00:   err = 1'b0;
         2'b01:   err = off[0];
         2'b10:   err = (off != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

   // Replace the strobed lanes of old_w with the matching lanes of new_w.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return merged;
   endfunction

   logic [31:0]      mem [MEM_WORDS];

   state_t           state;
   state_t           next_state;
   logic [3:0]       wait_cnt;

   // Registered address phase of the transfer currently in its data phase.
   logic             dp_valid;
   logic             dp_err;
   logic             dp_write;
   logic [IDX_W-1:0] dp_idx;
   logic [1:0]       dp_off;
   logic [1:0]       dp_size;

   logic             addr_ph_valid;
   logic             in_window;
   logic             addr_err;
   logic             accept;
   logic             ok_accept;
   logic [IDX_W-1:0] addr_idx;
   logic [1:0]       addr_off;

   logic             wr_en;
   logic [3:0]       wr_strb;
   logic [31:0]      rd_word;
   logic [31:0]      fwd_word;

   // Address-phase decode
   assign addr_ph_valid = (ahb_trans == 2'b10) || (ahb_trans == 2'b11);
   // The base is aligned to the window size, so the window test reduces to
   // comparing the bits above the window.
   assign in_window     = (ahb_addr[31:WIN_W] == BASE_ADDR[31:WIN_W]);
   assign addr_idx      = ahb_addr[WIN_W-1:2];
   assign addr_off      = ahb_addr[1:0];
   assign addr_err      = !in_window || align_err(ahb_size, addr_off);
   assign accept        = ahb_ready && addr_ph_valid;
   assign ok_accept     = accept && !addr_err;

   // Data-phase write: commits on the completing edge with wdata sampled then.
   assign wr_strb  = lane_strobe(dp_size, dp_off);
   assign wr_en    = ahb_ready && dp_valid && dp_write && !dp_err;

   // A write committing on the same edge as a read of the same word is
   // forwarded lane by lane, so write-then-read needs no extra cycle.
   assign rd_word  = mem[addr_idx];
   assign fwd_word = (wr_en && (dp_idx == addr_idx)) ?
                     lane_merge(rd_word, ahb_wdata, wr_strb) : rd_word;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_ERR2: begin
            if (accept && addr_err) begin
               next_state = ST_ERR1;
            end else if (accept && (WAIT_STATES > 0)) begin
               next_state = ST_WAIT;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt <= 4'd1) begin
               next_state = ST_IDLE;
            end
         end
         ST_ERR1: next_state = ST_ERR2;
         default: next_state = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ahb_ready = 1'b1;
      ahb_resp  = 1'b0;
      case (state)
         ST_WAIT: ahb_ready = 1'b0;
         ST_ERR1: begin
            ahb_ready = 1'b0;
            ahb_resp  = 1'b1;
         end
         ST_ERR2: ahb_resp = 1'b1;
         default: ;
      endcase
   end

   // Wait-state counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 4'd0;
      end else if (state == ST_WAIT) begin
         wait_cnt <= wait_cnt - 4'd1;
      end else if (ok_accept) begin
         wait_cnt <= WAIT_INIT;
      end
   end

   // Data-phase control and read data: only move on ready edges, so both
   // hold steady through wait and ERR1 cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dp_valid  <= 1'b0;
         dp_err    <= 1'b0;
         ahb_rdata <= 32'h0;
      end else if (ahb_ready) begin
         dp_valid  <= accept;
         dp_err    <= accept && addr_err;
         ahb_rdata <= (ok_accept && !ahb_write) ? fwd_word : 32'h0;
      end
   end

   // Address-phase capture
   always_ff @(posedge clk) begin
      if (accept) begin
         dp_write <= ahb_write;
         dp_idx   <= addr_idx;
         dp_off   <= addr_off;
         dp_size  <= ahb_size;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) begin
               mem[dp_idx][8*i +: 8] <= ahb_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_resp_mem.sv
// Directed bench for ahb_resp_mem. Two instances (0 and 3 wait states) share
// the bus; the unselected one only ever sees IDLE. A transaction-level model
// (byte array + one pending data phase) supplies the expected outputs checked
// on every falling edge, and literal expectations pin key results.
module tb_ahb_resp_mem;

   localparam int unsigned MW = 16;
   localparam logic [31:0] B  = 32'h0000_1000;
   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] ahb_addr = 32'h0;
   logic [31:0] ahb_wdata = 32'h0;
   logic [1:0]  bus_trans = T_IDLE;
   logic [1:0]  ahb_size = SZ_W;
   logic        ahb_write = 1'b0;
   logic        sel = 1'b0;

   logic [1:0]  trans0, trans3;
   logic [31:0] rdata0, rdata3, rdata_s;
   logic        ready0, ready3, ready_s;
   logic        resp0, resp3, resp_s;

   assign trans0  = sel ? T_IDLE : bus_trans;
   assign trans3  = sel ? bus_trans : T_IDLE;
   assign rdata_s = sel ? rdata3 : rdata0;
   assign ready_s = sel ? ready3 : ready0;
   assign resp_s  = sel ? resp3 : resp0;

   ahb_resp_mem #(.MEM_WORDS(MW), .BASE_ADDR(B), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(reset_n), .ahb_addr(ahb_addr), .ahb_trans(trans0),
      .ahb_write(ahb_write), .ahb_wdata(ahb_wdata), .ahb_size(ahb_size),
      .ahb_rdata(rdata0), .ahb_ready(ready0), .ahb_resp(resp0));

   ahb_resp_mem #(.MEM_WORDS(MW), .BASE_ADDR(B), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(reset_n), .ahb_addr(ahb_addr), .ahb_trans(trans3),
      .ahb_write(ahb_write), .ahb_wdata(ahb_wdata), .ahb_size(ahb_size),
      .ahb_rdata(rdata3), .ahb_ready(ready3), .ahb_resp(resp3));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: memory bytes per instance and the pending data phase.
   // p_kind 0 = none, 1 = OKAY transfer, 2 = ERROR transfer.
   logic [7:0]  mb [2][64];
   int          p_kind = 0;
   int          p_left = 0;
   int          p_estep = 0;
   logic        p_write = 1'b0;
   logic [31:0] p_addr = 32'h0;
   logic [1:0]  p_size = 2'b00;
   logic [31:0] p_wdata = 32'h0;
   logic [31:0] p_rdata = 32'h0;
   logic [31:0] stim_wd = 32'h0;

   int          low_cnt = 0;
   int          last_low = 0;
   logic [31:0] rise_rdata = 32'h0;

   function automatic logic m_ready();
      if (p_kind == 0) return 1'b1;
      if (p_kind == 1) return (p_left == 0);
      return (p_estep == 1);
   endfunction

   function automatic logic m_resp();
      return (p_kind == 2);
   endfunction

   function automatic logic [31:0] m_rdata();
      return (p_kind == 1 && !p_write) ? p_rdata : 32'h0;
   endfunction

   function automatic logic is_err(input logic [31:0] a, input logic [1:0] sz);
      if (a < B || a >= B + 32'(4 * MW)) return 1'b1;
      if (sz == SZ_X) return 1'b1;
      if (sz == SZ_W && a[1:0] != 2'b00) return 1'b1;
      if (sz == SZ_H && a[0] != 1'b0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      int o;
      o = int'(a - B) & ~3;
      return {mb[sel][o+3], mb[sel][o+2], mb[sel][o+1], mb[sel][o]};
   endfunction

   task automatic commit(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
      int o;
      int n;
      o = int'(a - B);
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
         mb[sel][o+i] = wd[8*((o+i)%4) +: 8];
      end
   endtask

   task automatic model_step();
      if (!reset_n) begin
         p_kind = 0;
         return;
      end
      if (m_ready()) begin
         if (p_kind == 1 && p_write) commit(p_addr, p_size, p_wdata);
         if (bus_trans == T_NSEQ || bus_trans == T_SEQ) begin
            if (is_err(ahb_addr, ahb_size)) begin
               p_kind  = 2;
               p_estep = 0;
            end else begin
               p_kind  = 1;
               p_left  = sel ? 3 : 0;
               p_write = ahb_write;
               p_addr  = ahb_addr;
               p_size  = ahb_size;
               p_wdata = stim_wd;
               p_rdata = ahb_write ? 32'h0 : word_of(ahb_addr);
            end
         end else begin
            p_kind = 0;
         end
      end else if (p_kind == 1) begin
         p_left--;
      end else begin
         p_estep = 1;
      end
   endtask

   // One clock: step the model at the edge, then drive data-phase wdata.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      ahb_wdata = (p_kind == 1 && p_write) ? p_wdata : 32'hDEAD_BEEF;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present an address phase and hold it until the edge that accepts it.
   task automatic xfer(input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [1:0] sz,
                       input logic [31:0] wd);
      logic acc;
      bus_trans = tr;
      ahb_addr  = a;
      ahb_write = w;
      ahb_size  = sz;
      stim_wd   = wd;
      for (int g = 0; g < 40; g++) begin
         acc = m_ready();
         tick();
         if (acc) return;
      end
      checks++;
      errors++;
      $display("FAIL xfer_timeout: addr %h not accepted", a);
   endtask

   // Go idle and check read data on the completing cycle of the current phase.
   task automatic wait_done(input string nm, input logic [31:0] exp);
      bus_trans = T_IDLE;
      for (int g = 0; g < 20; g++) begin
         @(negedge clk);
         if (ready_s) begin
            chk(nm, rdata_s, exp);
            tick();
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL %s: data phase never completed, ready %b", nm, ready_s);
   endtask

   // Per-cycle compare against the model, plus ready-low run tracking.
   initial begin
      forever begin
         @(negedge clk);
         checks++;
         if (ready_s !== m_ready() || resp_s !== m_resp() || rdata_s !== m_rdata()) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: ready %b resp %b rdata %h, model ready %b resp %b rdata %h",
                     $time, ready_s, resp_s, rdata_s, m_ready(), m_resp(), m_rdata());
         end
         if (!ready_s) begin
            low_cnt++;
         end else begin
            if (low_cnt != 0) begin
               last_low   = low_cnt;
               rise_rdata = rdata_s;
            end
            low_cnt = 0;
         end
      end
   end

   initial begin
      #12;
      chk("rst_ready0", 32'(ready0), 32'h1);
      chk("rst_resp0",  32'(resp0),  32'h0);
      chk("rst_rdata0", rdata0,      32'h0);
      chk("rst_ready3", 32'(ready3), 32'h1);
      chk("rst_resp3",  32'(resp3),  32'h0);
      chk("rst_rdata3", rdata3,      32'h0);
      #11 reset_n = 1'b1;
      tick();

      // ---------------- zero wait states ----------------
      xfer(T_NSEQ, B, 1'b1, SZ_W, 32'h1122_3344);
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      chk("fwd_rdata", rdata_s, 32'h1122_3344);
      chk("fwd_ready", 32'(ready_s), 32'h1);

      xfer(T_NSEQ, B + 3, 1'b1, SZ_B, 32'hAA55_5555);
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      chk("byte_merge", rdata_s, 32'hAA22_3344);
      xfer(T_NSEQ, B, 1'b1, SZ_H, 32'h7777_BEEF);
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      chk("half_merge", rdata_s, 32'hAA22_BEEF);

      xfer(T_NSEQ, B + 4, 1'b1, SZ_W, 32'hCAFE_F00D);
      xfer(T_SEQ,  B + 6, 1'b1, SZ_H, 32'h1234_5678);
      xfer(T_SEQ,  B + 5, 1'b1, SZ_B, 32'h0000_9900);
      xfer(T_SEQ,  B + 4, 1'b0, SZ_W, 32'h0);
      chk("mixed_lanes", rdata_s, 32'h1234_990D);

      // errors
      xfer(T_NSEQ, B + 2, 1'b0, SZ_W, 32'h0);
      chk("err_misalign_ready", 32'(ready_s), 32'h0);
      chk("err_misalign_resp",  32'(resp_s),  32'h1);
      chk("err_misalign_rdata", rdata_s,      32'h0);
      xfer(T_NSEQ, B + 32'(4 * MW), 1'b0, SZ_W, 32'h0);
      chk("err_window_ready", 32'(ready_s), 32'h0);
      chk("err_window_resp",  32'(resp_s),  32'h1);
      xfer(T_NSEQ, B + 2, 1'b1, SZ_W, 32'h0F0F_0F0F);
      xfer(T_NSEQ, B + 1, 1'b1, SZ_H, 32'h0F0F_0F0F);
      xfer(T_NSEQ, B, 1'b0, SZ_X, 32'h0);
      xfer(T_NSEQ, B - 4, 1'b0, SZ_W, 32'h0);
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      chk("err_nowrite", rdata_s, 32'hAA22_BEEF);

      // IDLE / BUSY interleaved
      xfer(T_IDLE, B, 1'b1, SZ_W, 32'h0);
      xfer(T_BUSY, B + 4, 1'b1, SZ_W, 32'hFFFF_FFFF);
      xfer(T_NSEQ, B + 4, 1'b0, SZ_W, 32'h0);
      chk("busy_b4", rdata_s, 32'h1234_990D);
      xfer(T_BUSY, B, 1'b1, SZ_B, 32'h0);
      xfer(T_SEQ, B, 1'b0, SZ_W, 32'h0);
      chk("busy_b0", rdata_s, 32'hAA22_BEEF);
      xfer(T_IDLE, B, 1'b0, SZ_W, 32'h0);
      xfer(T_IDLE, B, 1'b0, SZ_W, 32'h0);

      // ---------------- three wait states ----------------
      sel = 1'b1;
      xfer(T_IDLE, B, 1'b0, SZ_W, 32'h0);
      xfer(T_NSEQ, B, 1'b1, SZ_W, 32'h0102_0304);
      xfer(T_NSEQ, B + 8, 1'b1, SZ_W, 32'h0BAD_F00D);
      xfer(T_NSEQ, B + 8, 1'b0, SZ_W, 32'h0);
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      chk("ws3_low_run", 32'(last_low), 32'd3);
      chk("ws3_rdata", rise_rdata, 32'h0BAD_F00D);
      wait_done("ws3_rd_b", 32'h0102_0304);

      xfer(T_NSEQ, B + 32'(4 * MW), 1'b0, SZ_W, 32'h0);
      chk("ws3_err_ready", 32'(ready_s), 32'h0);
      chk("ws3_err_resp",  32'(resp_s),  32'h1);
      xfer(T_IDLE, B, 1'b0, SZ_W, 32'h0);
      chk("ws3_err_len", 32'(last_low), 32'd1);

      // reset during a waited write
      xfer(T_NSEQ, B + 8, 1'b1, SZ_W, 32'h5555_AAAA);
      bus_trans = T_IDLE;
      tick();
      #2 reset_n = 1'b0;
      p_kind = 0;
      #1;
      chk("rstw_ready", 32'(ready_s), 32'h1);
      chk("rstw_resp",  32'(resp_s),  32'h0);
      chk("rstw_rdata", rdata_s,      32'h0);
      tick();
      #3 reset_n = 1'b1;
      tick();
      xfer(T_NSEQ, B + 8, 1'b0, SZ_W, 32'h0);
      wait_done("rst_keep", 32'h0BAD_F00D);

      // reset during a waited read with data held
      xfer(T_NSEQ, B, 1'b0, SZ_W, 32'h0);
      bus_trans = T_IDLE;
      chk("rd_held", rdata_s, 32'h0102_0304);
      #2 reset_n = 1'b0;
      p_kind = 0;
      #1;
      chk("rstr_ready", 32'(ready_s), 32'h1);
      chk("rstr_rdata", rdata_s,      32'h0);
      tick();
      #3 reset_n = 1'b1;
      tick();
      xfer(T_NSEQ, B + 4 * 2, 1'b0, SZ_W, 32'h0);
      wait_done("final_rd", 32'h0BAD_F00D);
      tick();

      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
